// File: rtl/dsram_ctrl.sv
// dsram_ctrl
//   Data-memory responder between the CPU mem stage and the board's 32-bit
//   asynchronous SRAM. It accepts word-addressed read/write requests and
//   turns them into multi-cycle SRAM strobe sequences. A one-entry posted-write
//   buffer absorbs the single-cycle write_ce pulse so that a write is never
//   lost while the SRAM is busy.
//
//   Optional feature (compile-time macro WR_FWD_EN):
//     When defined, a read in IDLE that hits the buffered write address is
//     answered from the write buffer in one cycle, with no SRAM cycle.
//     When undefined, such a read waits for the buffer to drain.
//
// Ports
//   clk              system clock
//   rst              asynchronous reset, active low
//   read_ce          read request, held by the requester until rdata_valid
//   dram_read_addr   read word address (bit 20 selects another region)
//   write_ce         write request, single-cycle pulse
//   dram_write_addr  write word address, qualified by write_ce
//   wdata            write data, qualified by write_ce
//   ram_rdata        registered read data, held until the next read completes
//   rdata_valid      one-cycle pulse when ram_rdata is updated
//   busy             FSM not idle, or write buffer occupied
//   wr_ovf           sticky: a write was dropped because the buffer was full
//   sram_addr        SRAM word address
//   sram_dq_o        SRAM write data
//   sram_dq_oe       SRAM data bus drive enable
//   sram_dq_i        SRAM read data
//   sram_ce_n/oe_n/we_n  SRAM strobes, active low

module dsram_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_ce,
  input  logic [29:0]       dram_read_addr,
  input  logic              write_ce,
  input  logic [29:0]       dram_write_addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       ram_rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              wr_ovf,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  state_t            state_reg;
  logic [3:0]        wait_cnt_reg;
  logic              wb_valid_reg;
  logic [ADDR_W-1:0] wb_addr_reg;
  logic [31:0]       wb_data_reg;

  logic wr_in_region;
  logic rd_in_region;
  logic rd_req;
  logic wb_drain;
  logic wb_load;
  logic fwd_hit;
  logic unused_addr_bits;

  // Only bit 20 = 0 belongs to this block; the remaining upper address bits
  // are not decoded here.
  assign unused_addr_bits = ^{dram_read_addr, dram_write_addr};

  assign wr_in_region = write_ce && !dram_write_addr[20];
  assign rd_in_region = !dram_read_addr[20];

  // The requester keeps read_ce high during the cycle in which it sees
  // rdata_valid; that cycle must not start a second copy of the same read.
  assign rd_req = read_ce && !rdata_valid;

  // The buffer is emptied on the edge that moves IDLE into WR_SETUP, so a
  // new write arriving on that very edge can take its place.
  assign wb_drain = (state_reg == IDLE) && wb_valid_reg;
  assign wb_load  = wr_in_region && (!wb_valid_reg || wb_drain);

`ifdef WR_FWD_EN
  assign fwd_hit = (state_reg == IDLE) && rd_req && rd_in_region && wb_valid_reg &&
                   (dram_read_addr[ADDR_W-1:0] == wb_addr_reg);
`else
  assign fwd_hit = 1'b0;
`endif

  assign busy = (state_reg != IDLE) || wb_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_data_reg  <= 32'd0;
      ram_rdata    <= 32'd0;
      rdata_valid  <= 1'b0;
      wr_ovf       <= 1'b0;
      sram_addr    <= '0;
      sram_dq_o    <= 32'd0;
      sram_dq_oe   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;

      // Posted-write buffer
      if (wb_load) begin
        wb_valid_reg <= 1'b1;
        wb_addr_reg  <= dram_write_addr[ADDR_W-1:0];
        wb_data_reg  <= wdata;
      end else if (wb_drain) begin
        wb_valid_reg <= 1'b0;
      end

      if (wr_in_region && wb_valid_reg && !wb_drain) begin
        wr_ovf <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (fwd_hit) begin
            ram_rdata   <= wb_data_reg;
            rdata_valid <= 1'b1;
          end
          if (wb_valid_reg) begin
            // Writes drain before any read so memory order is preserved.
            state_reg  <= WR_SETUP;
            sram_addr  <= wb_addr_reg;
            sram_dq_o  <= wb_data_reg;
            sram_dq_oe <= 1'b1;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
          end else if (!wr_in_region && rd_req) begin
            // A write accepted on this edge goes first; the read is taken
            // once the buffer has drained.
            if (!rd_in_region) begin
              ram_rdata   <= 32'd0;
              rdata_valid <= 1'b1;
            end else begin
              state_reg    <= RD;
              sram_addr    <= dram_read_addr[ADDR_W-1:0];
              sram_dq_oe   <= 1'b0;
              sram_ce_n    <= 1'b0;
              sram_oe_n    <= 1'b0;
              sram_we_n    <= 1'b1;
              wait_cnt_reg <= 4'(RD_WAIT - 1);
            end
          end
        end

        RD: begin
          if (wait_cnt_reg == 4'd0) begin
            ram_rdata   <= sram_dq_i;
            rdata_valid <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        WR_SETUP: begin
          sram_we_n    <= 1'b0;
          wait_cnt_reg <= 4'(WR_WAIT - 1);
          state_reg    <= WR_PULSE;
        end

        WR_PULSE: begin
          if (wait_cnt_reg == 4'd0) begin
            sram_we_n <= 1'b1;
            state_reg <= WR_HOLD;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        WR_HOLD: begin
          // Data stays driven through the hold cycle after we_n rises.
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          state_reg  <= IDLE;
        end

        default: begin
          sram_dq_oe <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsram_ctrl.sv
// tb_dsram_ctrl
//   Directed bench for dsram_ctrl with default parameters. Inputs are driven
//   and outputs sampled 1 time unit after each rising clock edge.

module tb_dsram_ctrl;

  logic        clk;
  logic        rst;
  logic        read_ce;
  logic [29:0] dram_read_addr;
  logic        write_ce;
  logic [29:0] dram_write_addr;
  logic [31:0] wdata;
  logic [31:0] ram_rdata;
  logic        rdata_valid;
  logic        busy;
  logic        wr_ovf;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [31:0] sram_dq_i;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  dsram_ctrl #(
    .ADDR_W  (20),
    .RD_WAIT (1),
    .WR_WAIT (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .read_ce         (read_ce),
    .dram_read_addr  (dram_read_addr),
    .write_ce        (write_ce),
    .dram_write_addr (dram_write_addr),
    .wdata           (wdata),
    .ram_rdata       (ram_rdata),
    .rdata_valid     (rdata_valid),
    .busy            (busy),
    .wr_ovf          (wr_ovf),
    .sram_addr       (sram_addr),
    .sram_dq_o       (sram_dq_o),
    .sram_dq_oe      (sram_dq_oe),
    .sram_dq_i       (sram_dq_i),
    .sram_ce_n       (sram_ce_n),
    .sram_oe_n       (sram_oe_n),
    .sram_we_n       (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_strobes(input string tag, input logic ce_n, input logic oe_n,
                               input logic we_n, input logic dq_oe);
    check({tag, ".ce_n"},  32'(sram_ce_n),  32'(ce_n));
    check({tag, ".oe_n"},  32'(sram_oe_n),  32'(oe_n));
    check({tag, ".we_n"},  32'(sram_we_n),  32'(we_n));
    check({tag, ".dq_oe"}, 32'(sram_dq_oe), 32'(dq_oe));
  endtask

  initial begin
    rst             = 1'b0;
    read_ce         = 1'b0;
    dram_read_addr  = 30'd0;
    write_ce        = 1'b0;
    dram_write_addr = 30'd0;
    wdata           = 32'd0;
    sram_dq_i       = 32'd0;

    // ---------------- Reset values ----------------
    step();
    step();
    check("rst.ram_rdata",   ram_rdata,          32'd0);
    check("rst.rdata_valid", 32'(rdata_valid),   32'd0);
    check("rst.busy",        32'(busy),          32'd0);
    check("rst.wr_ovf",      32'(wr_ovf),        32'd0);
    check("rst.sram_addr",   32'(sram_addr),     32'd0);
    check("rst.sram_dq_o",   sram_dq_o,          32'd0);
    check_strobes("rst", 1'b1, 1'b1, 1'b1, 1'b0);
    $display("txn reset: outputs at reset values");
    rst = 1'b1;
    step();

    // ---------------- Read 0x10 ----------------
    read_ce        = 1'b1;
    dram_read_addr = 30'h00010;
    sram_dq_i      = 32'hDEADBEEF;
    step();
    check("rd.sram_addr", 32'(sram_addr), 32'h00010);
    check("rd.valid_early", 32'(rdata_valid), 32'd0);
    check("rd.busy", 32'(busy), 32'd1);
    check_strobes("rd.cyc", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check("rd.valid", 32'(rdata_valid), 32'd1);
    check("rd.data", ram_rdata, 32'hDEADBEEF);
    check_strobes("rd.done", 1'b1, 1'b1, 1'b1, 1'b0);
    read_ce = 1'b0;
    step();
    check("rd.valid_pulse", 32'(rdata_valid), 32'd0);
    check("rd.data_hold", ram_rdata, 32'hDEADBEEF);
    check("rd.busy_after", 32'(busy), 32'd0);
    $display("txn read addr=0x10 data=%08h", ram_rdata);

    // ---------------- Write 0x20 ----------------
    write_ce        = 1'b1;
    dram_write_addr = 30'h00020;
    wdata           = 32'h12345678;
    step();
    write_ce = 1'b0;
    check("wr.buf_busy", 32'(busy), 32'd1);
    check_strobes("wr.buffered", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("wr.setup_addr", 32'(sram_addr), 32'h00020);
    check("wr.setup_data", sram_dq_o, 32'h12345678);
    check("wr.setup_busy", 32'(busy), 32'd1);
    check_strobes("wr.setup", 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    check_strobes("wr.pulse1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("wr.pulse1_busy", 32'(busy), 32'd1);
    step();
    check_strobes("wr.pulse2", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_strobes("wr.hold", 1'b0, 1'b1, 1'b1, 1'b1);
    check("wr.hold_data", sram_dq_o, 32'h12345678);
    check("wr.hold_busy", 32'(busy), 32'd1);
    step();
    check_strobes("wr.idle", 1'b1, 1'b1, 1'b1, 1'b0);
    check("wr.addr_held", 32'(sram_addr), 32'h00020);
    check("wr.idle_busy", 32'(busy), 32'd0);
    $display("txn write addr=0x20 data=12345678");

    // ---------------- Back-to-back writes + overflow ----------------
    write_ce        = 1'b1;
    dram_write_addr = 30'h00040;
    wdata           = 32'h11111111;
    step();
    dram_write_addr = 30'h00041;
    wdata           = 32'h22222222;
    step();
    write_ce = 1'b0;
    check("b2b.first_addr", 32'(sram_addr), 32'h00040);
    check("b2b.first_data", sram_dq_o, 32'h11111111);
    check("b2b.no_ovf", 32'(wr_ovf), 32'd0);
    step();
    check("b2b.pulse", 32'(sram_we_n), 32'd0);
    write_ce        = 1'b1;
    dram_write_addr = 30'h00042;
    wdata           = 32'h33333333;
    step();
    write_ce = 1'b0;
    check("ovf.set", 32'(wr_ovf), 32'd1);
    check("ovf.pulse", 32'(sram_we_n), 32'd0);
    step();
    step();
    check("b2b.gap_ce", 32'(sram_ce_n), 32'd1);
    check("b2b.gap_busy", 32'(busy), 32'd1);
    step();
    check("b2b.second_addr", 32'(sram_addr), 32'h00041);
    check("b2b.second_data", sram_dq_o, 32'h22222222);
    check_strobes("b2b.second_setup", 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    step();
    step();
    check("b2b.done_busy", 32'(busy), 32'd0);
    check("ovf.sticky", 32'(wr_ovf), 32'd1);
    step();
    check("ovf.dropped_ce", 32'(sram_ce_n), 32'd1);
    check("ovf.dropped_addr", 32'(sram_addr), 32'h00041);
    $display("txn back-to-back writes 0x40,0x41; third write dropped wr_ovf=%0d", wr_ovf);

    // ---------------- Same-cycle write and read of 0x30 ----------------
    write_ce        = 1'b1;
    dram_write_addr = 30'h00030;
    wdata           = 32'hAAAA5555;
    read_ce         = 1'b1;
    dram_read_addr  = 30'h00030;
    sram_dq_i       = 32'hAAAA5555;
    step();
    write_ce = 1'b0;
    check("rw.no_early_read", 32'(sram_oe_n), 32'd1);
    check("rw.valid_early", 32'(rdata_valid), 32'd0);
`ifdef WR_FWD_EN
    step();
    check("rw.fwd_valid", 32'(rdata_valid), 32'd1);
    check("rw.fwd_data", ram_rdata, 32'hAAAA5555);
    check_strobes("rw.fwd_setup", 1'b0, 1'b1, 1'b1, 1'b1);
    read_ce = 1'b0;
    step();
    check_strobes("rw.fwd_pulse", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    step();
    check("rw.fwd_done_busy", 32'(busy), 32'd0);
    check("rw.fwd_no_oe", 32'(sram_oe_n), 32'd1);
    $display("txn write+read 0x30 forwarded data=%08h", ram_rdata);
`else
    step();
    check_strobes("rw.setup", 1'b0, 1'b1, 1'b1, 1'b1);
    check("rw.setup_addr", 32'(sram_addr), 32'h00030);
    step();
    check_strobes("rw.pulse1", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_strobes("rw.pulse2", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    check_strobes("rw.hold", 1'b0, 1'b1, 1'b1, 1'b1);
    check("rw.hold_valid", 32'(rdata_valid), 32'd0);
    step();
    check_strobes("rw.idle", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_strobes("rw.rd", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rw.rd_addr", 32'(sram_addr), 32'h00030);
    step();
    check("rw.rd_valid", 32'(rdata_valid), 32'd1);
    check("rw.rd_data", ram_rdata, 32'hAAAA5555);
    read_ce = 1'b0;
    step();
    check("rw.done_busy", 32'(busy), 32'd0);
    $display("txn write+read 0x30 write-then-read data=%08h", ram_rdata);
`endif

    // ---------------- Out-of-region read and write ----------------
    read_ce        = 1'b1;
    dram_read_addr = 30'h100010;
    sram_dq_i      = 32'hCAFEF00D;
    step();
    check("oor.valid", 32'(rdata_valid), 32'd1);
    check("oor.data", ram_rdata, 32'd0);
    check_strobes("oor.rd", 1'b1, 1'b1, 1'b1, 1'b0);
    read_ce = 1'b0;
    step();
    check("oor.valid_pulse", 32'(rdata_valid), 32'd0);
    write_ce        = 1'b1;
    dram_write_addr = 30'h100020;
    wdata           = 32'h0BADF00D;
    step();
    write_ce = 1'b0;
    check("oor.wr_busy", 32'(busy), 32'd0);
    step();
    check("oor.wr_ce", 32'(sram_ce_n), 32'd1);
    $display("txn out-of-region read/write ignored");

    // ---------------- Reset during WR_PULSE ----------------
    write_ce        = 1'b1;
    dram_write_addr = 30'h00050;
    wdata           = 32'h77777777;
    step();
    write_ce = 1'b0;
    step();
    step();
    check("arst.pre_we", 32'(sram_we_n), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check_strobes("arst.async", 1'b1, 1'b1, 1'b1, 1'b0);
    check("arst.addr", 32'(sram_addr), 32'd0);
    check("arst.dq_o", sram_dq_o, 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.wr_ovf", 32'(wr_ovf), 32'd0);
    check("arst.ram_rdata", ram_rdata, 32'd0);
    check("arst.valid", 32'(rdata_valid), 32'd0);
    step();
    rst = 1'b1;
    step();
    step();
    check("arst.buf_empty", 32'(busy), 32'd0);
    check("arst.no_drain", 32'(sram_ce_n), 32'd1);
    $display("txn async reset during write pulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsram_ctrl.md
Name: dsram_ctrl

Overview:
- Responder for the data-memory request interface driven by the CPU memory stage. Receives word-addressed read/write requests (read_ce, dram_read_addr, write_ce, dram_write_addr, wdata) and returns ram_rdata.
- Turns those requests into multi-cycle asynchronous-SRAM cycles on the external 32-bit data SRAM.
- Holds a one-entry posted-write buffer, so the single-cycle write_ce pulse from the CPU is never lost.
- Sits between the CPU mem stage and the board SRAM pins.

Parameters:
- ADDR_W, 20, external SRAM word-address width (taken from dram address bits [ADDR_W-1:0]).
- RD_WAIT, 1, SRAM read-access cycles with oe_n low before data capture (legal range 1..15).
- WR_WAIT, 2, cycles we_n is held low per write (legal range 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- read_ce  in  1  read request; held high by the requester until rdata_valid.
- dram_read_addr  in  30  read word address.
- write_ce  in  1  write request, single-cycle pulse.
- dram_write_addr  in  30  write word address, qualified by write_ce.
- wdata  in  32  write data, qualified by write_ce.
- ram_rdata  out  32  read data, registered, held until the next read completes.
- rdata_valid  out  1  one-cycle pulse: ram_rdata updated for the current read.
- busy  out  1  high when state != IDLE or the write buffer is full.
- wr_ovf  out  1  sticky: write_ce arrived while the buffer was full and not draining.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_o  out  32  SRAM write data.
- sram_dq_oe  out  1  drive enable for the data bus.
- sram_dq_i  in  32  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low.
- Reset values:
  - ram_rdata=0, rdata_valid=0, busy=0, wr_ovf=0.
  - sram_addr=0, sram_dq_o=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - Write buffer empty, state IDLE, wait counter 0.
- Reset mid-cycle: asserting rst during any SRAM cycle aborts it immediately. Strobes are deasserted asynchronously and the buffered write is discarded.
- Region decode: only addresses with bit 20 = 0 belong to this block.
  - Write with bit 20 = 1 is ignored: no buffer load, no wr_ovf.
  - Read with bit 20 = 1 completes next cycle with ram_rdata=0 and rdata_valid=1, no SRAM cycle.
- Write buffer (wb_valid, wb_addr, wb_data):
  - Loads on write_ce when empty, or in the same edge that the buffer leaves for WR_SETUP.
  - Otherwise write_ce with a full buffer sets wr_ovf; the new write is dropped.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
  - IDLE: if wb_valid, go to WR_SETUP (writes drain before reads, preserving order). Else if read_ce, go to RD and latch the address. Else stay.
  - RD: ce_n=0, oe_n=0, dq_oe=0, counter preset to RD_WAIT-1. When the counter reaches 0: capture sram_dq_i into ram_rdata, pulse rdata_valid, return to IDLE.
  - WR_SETUP: 1 cycle; addr and data driven, dq_oe=1, ce_n=0, we_n=1; buffer is freed.
  - WR_PULSE: we_n=0 for WR_WAIT cycles.
  - WR_HOLD: 1 cycle; we_n=1, data still driven. Then IDLE.
- Latency with defaults:
  - Read from IDLE with empty buffer: request seen at edge N; RD during cycle N+1; ram_rdata and rdata_valid valid after edge N+1.
  - Write occupies 1+WR_WAIT+1 = 4 cycles.
- Simultaneous write_ce and read_ce in IDLE with empty buffer: the write is buffered and drained first; the read follows.
- sram_oe_n and sram_we_n are never both low. dq_oe=1 only in the WR_* states.
- Outside an active cycle, strobes are high and sram_addr holds its last value.

Optional Feature:
- Macro WR_FWD_EN.
- Defined: in IDLE, a read whose address equals wb_addr while wb_valid is served from wb_data. ram_rdata=wb_data and rdata_valid is pulsed the next cycle; no SRAM cycle runs and the buffer stays full for a later drain.
- Undefined: the read waits until the buffer drains, then runs a normal RD cycle.

Test Plan:
- Reset, then read_ce at addr 0x00010, sram_dq_i=0xDEADBEEF -> sram_oe_n low 1 cycle, ram_rdata=0xDEADBEEF, rdata_valid pulse 2 edges after request.
- write_ce pulse, addr 0x00020, wdata 0x12345678 -> sram_addr=0x20, dq_o=0x12345678, we_n low exactly 2 cycles inside the 4-cycle frame, busy high throughout.
- Two write_ce pulses 1 cycle apart -> second is buffered, both written in order, wr_ovf=0. A third pulse while the buffer is full and WR_PULSE is active -> wr_ovf=1 and stays 1 until reset.
- Same-cycle write 0xAAAA5555 to 0x30 and read of 0x30 -> write completes before RD starts. With WR_FWD_EN, the read returns 0xAAAA5555 in 1 cycle and no oe_n pulse occurs before the write.
- Read at addr with bit 20 set -> rdata_valid next cycle, ram_rdata=0, SRAM strobes stay high.
- rst driven low during WR_PULSE -> we_n/ce_n go high asynchronously, buffer empty, all outputs at reset values.
